count_seq_monitor: RTL
======================

// Module: count_seq_monitor
// PURPOSE
// - Observer for the 8-bit counter output bus (glitchOut) of the counter under test.
// - Samples the bus on a strobe and checks that each sample equals the previous sample plus STEP, modulo 2^WIDTH.
// - Flags glitches, counts them and reports lock status, so a board or bench can score counter integrity without waveforms.
// PARAMETERS
// - WIDTH    8  width of the observed count bus
// - STEP     1  expected increment per valid sample, modulo 2^WIDTH
// - LOCK_CNT 4  consecutive in-sequence samples needed for lock (includes the first sample); legal range >=2
// - ERR_W    8  width of the saturating error counter
// PORTS
// - clk      in   1       rising-edge clock
// - rst      in   1       synchronous, active-high reset
// - cnt_in   in   WIDTH   observed counter value
// - cnt_vld  in   1       cnt_in is sampled on a clock edge where cnt_vld=1
// - clr_err  in   1       clears err_cnt and err_sticky
// - locked   out  1       monitor is tracking a valid sequence
// - glitch   out  1       one-cycle pulse per in-lock mismatch
// - err_sticky out 1      set on any glitch; held until clr_err or rst
// - err_cnt  out  ERR_W   number of glitches; saturates at all-ones
// - expected out  WIDTH   next expected value (prev+STEP), registered
// BEHAVIOUR
// - Reset (sync, rst=1 at an edge): state IDLE, internal prev=0, good=0. All outputs are 0, including expected.
// - All outputs are registered. Response appears in the cycle after the sampling edge.
// - cnt_vld=0: nothing changes, and glitch=0.
// - Matching is modulo 2^WIDTH, so FF->00 with STEP=1 is a match.
// - FSM states: IDLE, SYNC, TRACK.
//   - IDLE: on cnt_vld, prev<=cnt_in and good<=1; go to SYNC.
//   - SYNC: on cnt_vld with a match, prev<=cnt_in and good<=good+1. When good+1==LOCK_CNT: go to TRACK, locked<=1.
//   - SYNC: on a mismatch, prev<=cnt_in and good<=1. Stay in SYNC. No error is counted while unlocked.
//   - TRACK: on cnt_vld with a match, prev<=cnt_in.
//   - TRACK: on a mismatch, glitch<=1 for one cycle, err_sticky<=1, err_cnt<=sat(err_cnt+1), prev<=cnt_in, good<=1, locked<=0; go to SYNC.
// - expected<=cnt_in+STEP on every valid sample, in every state.
// - An external counter reset mid-count (value jumps to 0) while in TRACK is a mismatch and is counted as a glitch.
// - clr_err=1 clears err_cnt and err_sticky, with one exception: if clr_err coincides with a TRACK mismatch, the new error wins (err_cnt=1, err_sticky=1).
// - clr_err does not affect state, locked, prev or glitch.
// - rst has priority over every other input, including mid-TRACK.
// CONFIGURATION
// - MON_CAPTURE_EN defined: adds output ports bad_val[WIDTH] and bad_exp[WIDTH].
//   - They latch cnt_in and the expected value on the first glitch after rst or clr_err, and hold until rst or clr_err.
//   - On the same-cycle clr_err+glitch case, they latch that glitch.
//   - Both reset to 0.
// - MON_CAPTURE_EN undefined: the ports and capture logic are absent. All other behaviour is identical.
// TESTING
// - Reset, then cnt_vld=1 with 00,01,02,03,04... -> locked=1 the cycle after sample 03; glitch never asserts; err_cnt=0.
// - Locked, then feed FD,FE,FF,00,01 -> no glitch, locked stays 1; expected=02 after sample 01.
// - Locked at 10, inject 13 instead of 11 -> one-cycle glitch, err_cnt=1, err_sticky=1, locked=0. Then 14,15,16 -> relock after 16.
// - Alternate bad/good runs to force 300 in-lock glitches with ERR_W=8 -> err_cnt holds at FF; err_sticky=1.
// - clr_err same cycle as a TRACK mismatch -> err_cnt=1, err_sticky=1. clr_err alone on a later cycle -> both 0; locked unchanged.
// - rst mid-TRACK (counter at 0x42) -> next cycle all outputs 0, state IDLE. cnt_vld=0 for 5 cycles -> outputs hold at 0.

Source files
------------

// File: rtl/count_seq_monitor.sv
// count_seq_monitor: watches a free-running counter bus and checks that each
// strobed sample equals the previous sample plus STEP (modulo 2^WIDTH).
// Reports lock status, one-cycle glitch pulses, a sticky error flag and a
// saturating glitch count.
// Optional feature macro: MON_CAPTURE_EN adds bad_val/bad_exp ports that hold
// the observed and expected values of the first glitch since rst or clr_err.
module count_seq_monitor #(
  parameter int WIDTH    = 8,
  parameter int STEP     = 1,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             cnt_vld,
  input  logic             clr_err,
  output logic             locked,
  output logic             glitch,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_cnt,
  output logic [WIDTH-1:0] expected
`ifdef MON_CAPTURE_EN
  ,
  output logic [WIDTH-1:0] bad_val,
  output logic [WIDTH-1:0] bad_exp
`endif
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SYNC  = 2'd1;
  localparam logic [1:0] S_TRACK = 2'd2;

  localparam logic [WIDTH-1:0]  STEP_V = WIDTH'(STEP);
  localparam logic [GOOD_W-1:0] LOCK_V = GOOD_W'(LOCK_CNT);
  localparam logic [GOOD_W-1:0] ONE_V  = GOOD_W'(1);

  logic [1:0]        state_q,      state_d;
  logic [WIDTH-1:0]  prev_q,       prev_d;
  logic [GOOD_W-1:0] good_q,       good_d;
  logic              locked_q,     locked_d;
  logic              glitch_q,     glitch_d;
  logic              err_sticky_q, err_sticky_d;
  logic [ERR_W-1:0]  err_cnt_q,    err_cnt_d;
  logic [WIDTH-1:0]  expected_q,   expected_d;

  logic [WIDTH-1:0]  exp_val;
  logic [GOOD_W-1:0] good_inc;
  logic              match;
  logic              miss;

  // Value the current sample must equal to stay in sequence (wraps naturally).
  assign exp_val  = prev_q + STEP_V;
  assign match    = (cnt_in == exp_val);
  assign good_inc = good_q + ONE_V;

  // Sequence-tracking FSM: next state, match run length and lock/glitch flags.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    prev_d     = prev_q;
    good_d     = good_q;
    locked_d   = locked_q;
    glitch_d   = 1'b0;
    expected_d = expected_q;
    miss       = 1'b0;
    if (cnt_vld) begin
      prev_d     = cnt_in;
      expected_d = cnt_in + STEP_V;
      case (state_q)
        S_IDLE: begin
          good_d  = ONE_V;
          state_d = S_SYNC;
        end
        S_SYNC: begin
          if (match) begin
            good_d = good_inc;
            if (good_inc == LOCK_V) begin
              state_d  = S_TRACK;
              locked_d = 1'b1;
            end
          end else begin
            // Restart the run; this sample is the first of the new run.
            good_d = ONE_V;
          end
        end
        S_TRACK: begin
          if (!match) begin
            miss     = 1'b1;
            glitch_d = 1'b1;
            good_d   = ONE_V;
            locked_d = 1'b0;
            state_d  = S_SYNC;
          end
        end
        default: begin
          state_d  = S_IDLE;
          good_d   = '0;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  // Error bookkeeping: a glitch on the same edge as clr_err wins over the clear.
  always_comb begin
    err_sticky_d = err_sticky_q;
    err_cnt_d    = err_cnt_q;
    if (miss) begin
      err_sticky_d = 1'b1;
      if (clr_err)               err_cnt_d = ERR_W'(1);
      else if (err_cnt_q != '1)  err_cnt_d = err_cnt_q + ERR_W'(1);
    end else if (clr_err) begin
      err_sticky_d = 1'b0;
      err_cnt_d    = '0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q      <= S_IDLE;
      prev_q       <= '0;
      good_q       <= '0;
      locked_q     <= 1'b0;
      glitch_q     <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
      expected_q   <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      good_q       <= good_d;
      locked_q     <= locked_d;
      glitch_q     <= glitch_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
      expected_q   <= expected_d;
    end
  end

  assign locked     = locked_q;
  assign glitch     = glitch_q;
  assign err_sticky = err_sticky_q;
  assign err_cnt    = err_cnt_q;
  assign expected   = expected_q;

`ifdef MON_CAPTURE_EN
  logic             cap_q;
  logic [WIDTH-1:0] bad_val_q;
  logic [WIDTH-1:0] bad_exp_q;

  // Capture the first glitch since rst/clr_err; a glitch on the clearing edge
  // is itself the first one of the new window.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q     <= 1'b0;
      bad_val_q <= '0;
      bad_exp_q <= '0;
    end else if (miss && (clr_err || !cap_q)) begin
      cap_q     <= 1'b1;
      bad_val_q <= cnt_in;
      bad_exp_q <= exp_val;
    end else if (clr_err) begin
      cap_q     <= 1'b0;
      bad_val_q <= '0;
      bad_exp_q <= '0;
    end
  end

  assign bad_val = bad_val_q;
  assign bad_exp = bad_exp_q;
`endif

endmodule
